// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection and stall sequencing with memory-wait freeze.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_stall_unit #(
    parameter int              REG_AW   = 5,
    parameter int              OP_W     = 6,
    parameter int              LOAD_LAT = 1,
    parameter logic [OP_W-1:0] LW_OP    = 6'b100011,
    parameter logic [OP_W-1:0] XORI_OP  = 6'b001110,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EX_MemoryRead,
    input  logic [REG_AW-1:0] EX_rt,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic [OP_W-1:0]   ID_Op,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              PC_WriteEnable,
    output logic              IFID_WriteEnable,
    output logic              StallFlush,
    output logic              PipeFreeze
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  freeze_cycles
`endif
);

    localparam int                REM_W    = $clog2(LOAD_LAT + 1);
    localparam logic [REM_W-1:0]  REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0]  REM_ONE  = REM_W'(1);

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             hazard;
    logic             mem_wait;
    logic             stall;

    always_comb begin
        // rt only counts as a source for opcodes that do not write it.
        hazard = EX_MemoryRead && (EX_rt != '0) &&
                 ((EX_rt == ID_rs) ||
                  ((EX_rt == ID_rt) && (ID_Op != LW_OP) && (ID_Op != XORI_OP)));
        mem_wait = mem_req && !mem_ready;
        stall    = ((state_q == IDLE) && hazard) || (state_q == LOAD_STALL);

        state_d          = state_q;
        rem_d            = rem_q;
        PC_WriteEnable   = 1'b1;
        IFID_WriteEnable = 1'b1;
        StallFlush       = 1'b0;
        PipeFreeze       = 1'b0;

        if (reset) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (mem_wait) begin
            // Freeze pauses the stall sequence without consuming any of it.
            PipeFreeze       = 1'b1;
            PC_WriteEnable   = 1'b0;
            IFID_WriteEnable = 1'b0;
        end else begin
            PC_WriteEnable   = !stall;
            IFID_WriteEnable = !stall;
            StallFlush       = stall;
            case (state_q)
                IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_d = LOAD_STALL;
                        rem_d   = REM_INIT;
                    end
                end
                LOAD_STALL: begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef HAZARD_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q, StallFlush);
        freeze_cnt_d = sat_inc(freeze_cnt_q, PipeFreeze);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign freeze_cycles = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: three latency variants share one stimulus stream.
module tb_hazard_stall_unit;

    localparam logic [3:0] RUN = 4'b1100;  // {PC_WE, IFID_WE, StallFlush, PipeFreeze}
    localparam logic [3:0] STL = 4'b0010;
    localparam logic [3:0] FRZ = 4'b0001;
    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_XO = 6'b001110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ex_rd = 1'b0;
    logic [4:0] ex_rt = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic [5:0] id_op = '0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] o1, o3, o4;

    typedef struct {
        int         idx;
        logic [3:0] e1;
        logic [3:0] e3;
        logic [3:0] e4;
        bit         cc;
        int         es;
        int         ef;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vidx = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
    logic [15:0] sc1, fc1, sc3, fc3, sc4, fc4;
    logic [3:0]  os;
    logic [3:0]  scs, fcs;
`endif

    hazard_stall_unit #(.LOAD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .EX_MemoryRead(ex_rd), .EX_rt(ex_rt),
        .ID_rs(id_rs), .ID_rt(id_rt), .ID_Op(id_op), .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_WriteEnable(o1[3]), .IFID_WriteEnable(o1[2]), .StallFlush(o1[1]), .PipeFreeze(o1[0])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc1), .freeze_cycles(fc1)
`endif
    );

    hazard_stall_unit #(.LOAD_LAT(3)) u3 (
        .clk(clk), .reset(reset), .EX_MemoryRead(ex_rd), .EX_rt(ex_rt),
        .ID_rs(id_rs), .ID_rt(id_rt), .ID_Op(id_op), .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_WriteEnable(o3[3]), .IFID_WriteEnable(o3[2]), .StallFlush(o3[1]), .PipeFreeze(o3[0])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc3), .freeze_cycles(fc3)
`endif
    );

    hazard_stall_unit #(.LOAD_LAT(4)) u4 (
        .clk(clk), .reset(reset), .EX_MemoryRead(ex_rd), .EX_rt(ex_rt),
        .ID_rs(id_rs), .ID_rt(id_rt), .ID_Op(id_op), .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_WriteEnable(o4[3]), .IFID_WriteEnable(o4[2]), .StallFlush(o4[1]), .PipeFreeze(o4[0])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc4), .freeze_cycles(fc4)
`endif
    );

`ifdef HAZARD_STATS_EN
    hazard_stall_unit #(.LOAD_LAT(1), .CNT_W(4)) u_stat (
        .clk(clk), .reset(reset), .EX_MemoryRead(ex_rd), .EX_rt(ex_rt),
        .ID_rs(id_rs), .ID_rt(id_rt), .ID_Op(id_op), .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_WriteEnable(os[3]), .IFID_WriteEnable(os[2]), .StallFlush(os[1]), .PipeFreeze(os[0]),
        .stall_cycles(scs), .freeze_cycles(fcs)
    );
`endif

    task automatic vec(input bit r, input bit rd, input int ex, input int rs, input int rt,
                       input logic [5:0] op, input bit rq, input bit ry,
                       input logic [3:0] x1, input logic [3:0] x3, input logic [3:0] x4,
                       input bit cc = 1'b0, input int es = 0, input int ef = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = r;
        ex_rd     = rd;
        ex_rt     = 5'(ex);
        id_rs     = 5'(rs);
        id_rt     = 5'(rt);
        id_op     = op;
        mem_req   = rq;
        mem_ready = ry;
        e.idx = vidx;
        e.e1  = x1;
        e.e3  = x3;
        e.e4  = x4;
        e.cc  = cc;
        e.es  = es;
        e.ef  = ef;
        exp_q.push_back(e);
        vidx++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL vec%0d %s got %b expected %b", idx, nm, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle, so pop one expectation per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("lat1", e.idx, o1, e.e1);
            chk("lat3", e.idx, o3, e.e3);
            chk("lat4", e.idx, o4, e.e4);
`ifdef HAZARD_STATS_EN
            chk("stat_out", e.idx, os, e.e1);
            if (e.cc) begin
                chk("stall_cycles", e.idx, scs, 4'(e.es));
                chk("freeze_cycles", e.idx, fcs, 4'(e.ef));
            end
`endif
        end
    end

    initial begin
        int n;
        // reset and release
        vec(1, 0, 0, 0, 0, OP_R, 0, 0, RUN, RUN, RUN);
        vec(0, 0, 0, 0, 0, OP_R, 0, 0, RUN, RUN, RUN);
        // rs hazard, single and multi-cycle stall lengths
        vec(0, 1, 8, 8, 0, OP_R, 0, 0, STL, STL, STL);
        vec(0, 0, 8, 8, 0, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 0, 8, 8, 0, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 0, 8, 8, 0, OP_R, 0, 0, RUN, RUN, STL);
        vec(0, 0, 8, 8, 0, OP_R, 0, 0, RUN, RUN, RUN);
        // rt hazard; hazard re-asserted mid-stall is ignored
        vec(0, 1, 9, 2, 9, OP_R, 0, 0, STL, STL, STL);
        vec(0, 0, 9, 2, 9, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 1, 9, 2, 9, OP_R, 0, 0, STL, STL, STL);
        vec(0, 0, 9, 2, 9, OP_R, 0, 0, RUN, RUN, STL);
        vec(0, 0, 9, 2, 9, OP_R, 0, 0, RUN, RUN, RUN);
        // back-to-back hazard restarts a full stall on return to IDLE
        vec(0, 1, 9, 2, 9, OP_R, 0, 0, STL, STL, STL);
        vec(0, 0, 9, 2, 9, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 1, 9, 2, 9, OP_R, 0, 0, STL, STL, STL);
        vec(0, 1, 9, 2, 9, OP_R, 0, 0, STL, STL, STL);
        vec(0, 0, 9, 2, 9, OP_R, 0, 0, RUN, STL, RUN);
        vec(0, 0, 9, 2, 9, OP_R, 0, 0, RUN, STL, RUN);
        vec(0, 0, 9, 2, 9, OP_R, 0, 0, RUN, RUN, RUN);
        // rt not a source for lw/xori; register 0 never hazards
        vec(0, 1, 9, 2, 9, OP_LW, 0, 0, RUN, RUN, RUN);
        vec(0, 1, 9, 2, 9, OP_XO, 0, 0, RUN, RUN, RUN);
        vec(0, 1, 0, 0, 0, OP_R, 0, 0, RUN, RUN, RUN);
        vec(0, 1, 9, 9, 0, OP_LW, 0, 0, STL, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, RUN);
        // memory wait during a stall pauses it
        vec(0, 1, 9, 9, 0, OP_R, 0, 0, STL, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 1, 0, FRZ, FRZ, FRZ);
        vec(0, 0, 9, 9, 0, OP_R, 1, 0, FRZ, FRZ, FRZ);
        vec(0, 0, 9, 9, 0, OP_R, 1, 1, RUN, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, RUN);
        vec(0, 1, 9, 9, 0, OP_R, 1, 0, FRZ, FRZ, FRZ);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, RUN);
        // reset in the second stall cycle overrides everything
        vec(0, 1, 9, 9, 0, OP_R, 0, 0, STL, STL, STL);
        vec(1, 1, 9, 9, 0, OP_R, 1, 0, RUN, RUN, RUN);
        vec(0, 1, 9, 9, 0, OP_R, 0, 0, STL, STL, STL, 1'b1, 0, 0);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, STL, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, STL);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, RUN);
        // sustained hazard: 24 cycles returns both multi-cycle variants to IDLE
        for (int i = 0; i < 24; i++) begin
            vec(0, 1, 9, 9, 0, OP_R, 0, 0, STL, STL, STL);
        end
        vec(0, 0, 9, 9, 0, OP_R, 1, 0, FRZ, FRZ, FRZ);
        vec(0, 0, 9, 9, 0, OP_R, 1, 0, FRZ, FRZ, FRZ);
        vec(0, 0, 9, 9, 0, OP_R, 0, 0, RUN, RUN, RUN, 1'b1, 15, 2);

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
